serial_mag_cmp: RTL

Parametrised, sequential, MSB-first magnitude comparator for two WIDTH-bit operands, supporting unsigned and two's-complement modes. It examines one bit pair per clock and terminates early at the first differing bit. A start/done handshake drives it, and it holds GT/EQ/LT flags and a bit-count for display on board LEDs. It is the bit-serial, width-generic successor to the team's fixed 3-bit combinational comparator.

---
 rtl/serial_mag_cmp.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: bit-serial, MSB-first magnitude comparator for two WIDTH-bit
// operands in unsigned or two's-complement mode. One bit pair is examined per
// clock and the compare stops at the first differing pair.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - request a compare (sampled in IDLE only)
//   mode   - 0 = unsigned, 1 = signed two's complement (latched with start)
//   a, b   - operands (latched with start)
//   busy   - high while bit pairs are being examined
//   done   - one-cycle pulse when gt/eq/lt/nbits are valid
//   gt, eq, lt - result flags, held until the next accepted start
//   nbits  - bit pairs examined in the last compare (1..WIDTH)
//   led    - {gt, eq, lt} for board display
module serial_mag_cmp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    nbits,
  output logic [2:0]       led
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MsbIdx = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    nbits_q, nbits_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      nbits_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      nbits_q <= nbits_d;
    end
  end

  logic ai, bi, sign_pos;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    nbits_d  = nbits_q;
    ai       = a_q[idx_q];
    bi       = b_q[idx_q];
    sign_pos = mode_q && (idx_q == MsbIdx);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          idx_d   = MsbIdx;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          nbits_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        nbits_d = nbits_q + CW'(1);
        if (ai != bi) begin
          // A set bit means "larger" except at the signed sign bit, where it
          // means negative; XOR with sign_pos folds both cases together.
          if (ai ^ sign_pos) gt_d = 1'b1;
          else               lt_d = 1'b1;
          state_d = StDone;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All outputs decode straight from registers; no input reaches them combinationally.
  assign busy  = (state_q == StShift);
  assign done  = (state_q == StDone);
  assign gt    = gt_q;
  assign eq    = eq_q;
  assign lt    = lt_q;
  assign nbits = nbits_q;
  assign led   = {gt_q, eq_q, lt_q};

endmodule
